// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - MIPS execute stage: ALU, iterative mul/div with HI/LO, EXE/MEM register
// Mul/div stalls the front of the pipe for 33 cycles; the instruction leaves EXE in the DONE cycle.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic        ejal,
  input  logic        ealuimm,
  input  logic [4:0]  ealuc,
  input  logic [4:0]  eshamt,
  input  logic [29:0] epc4,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  input  logic [4:0]  ern,
  output logic        stall,
  output logic [31:0] ealu,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [31:0] malu,
  output logic [31:0] mb,
  output logic [4:0]  mrn,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_LUI  = 5'd11;
  localparam logic [4:0] OP_SLLV = 5'd12, OP_SRLV = 5'd13, OP_SRAV = 5'd14;
  localparam logic [4:0] OP_MULT = 5'd16, OP_DIV  = 5'd18;
  localparam logic [4:0] OP_MFHI = 5'd20, OP_MFLO = 5'd21, OP_MTHI = 5'd22, OP_MTLO = 5'd23;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] mcand_q;
  logic [63:0] p_q;
  logic        is_div_q, neg_lo_q, neg_hi_q, div0_q;
  logic [31:0] hi_q, lo_q;
  logic        mwreg_q, mm2reg_q, mwmem_q;
  logic [31:0] malu_q, mb_q;
  logic [4:0]  mrn_q;

  logic [31:0] b, alu_res;
  logic        is_md, md_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem_sh, div_diff;
  logic [63:0] mul_next, div_next, p_step, prod_fix;
  logic [31:0] div_lo, div_hi;

  assign b         = ealuimm ? eimm : eb;
  assign is_md     = (ealuc[4:2] == 3'b100);
  assign md_signed = (ealuc == OP_MULT) || (ealuc == OP_DIV);

  always_comb begin
    alu_res = 32'h0;
    case (ealuc)
      OP_ADD:  alu_res = ea + b;
      OP_SUB:  alu_res = ea - b;
      OP_AND:  alu_res = ea & b;
      OP_OR:   alu_res = ea | b;
      OP_XOR:  alu_res = ea ^ b;
      OP_NOR:  alu_res = ~(ea | b);
      OP_SLT:  alu_res = {31'h0, $signed(ea) < $signed(b)};
      OP_SLTU: alu_res = {31'h0, ea < b};
      OP_SLL:  alu_res = eb << eshamt;
      OP_SRL:  alu_res = eb >> eshamt;
      OP_SRA:  alu_res = $unsigned($signed(eb) >>> eshamt);
      OP_LUI:  alu_res = {b[15:0], 16'h0};
      OP_SLLV: alu_res = eb << ea[4:0];
      OP_SRLV: alu_res = eb >> ea[4:0];
      OP_SRAV: alu_res = $unsigned($signed(eb) >>> ea[4:0]);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = 32'h0;
    endcase
  end

  assign ealu = ejal ? ({epc4, 2'b00} + 32'd4) : alu_res;

  // p_q holds {acc, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    a_mag    = (md_signed && ea[31]) ? -ea : ea;
    b_mag    = (md_signed && b[31])  ? -b  : b;
    mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mcand_q} : 33'h0);
    mul_next = {mul_sum, p_q[31:1]};
    rem_sh   = {p_q[63:32], p_q[31]};
    div_diff = rem_sh - {1'b0, mcand_q};
    div_next = div_diff[32] ? {rem_sh[31:0], p_q[30:0], 1'b0}
                            : {div_diff[31:0], p_q[30:0], 1'b1};
    p_step   = is_div_q ? div_next : mul_next;
    prod_fix = neg_lo_q ? -p_step : p_step;
    div_lo   = div0_q ? 32'hFFFF_FFFF : (neg_lo_q ? -p_step[31:0] : p_step[31:0]);
    div_hi   = neg_hi_q ? -p_step[63:32] : p_step[63:32];
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (is_md) state_d = S_BUSY;
      S_BUSY:  if (count_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:  stall = is_md;
      S_BUSY:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= 5'h0;
      mcand_q  <= 32'h0;
      p_q      <= 64'h0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_md) begin
            mcand_q  <= b_mag;
            p_q      <= {32'h0, a_mag};
            is_div_q <= ealuc[1];
            neg_lo_q <= md_signed && (ea[31] ^ b[31]);
            neg_hi_q <= md_signed && (ealuc[1] ? ea[31] : (ea[31] ^ b[31]));
            div0_q   <= (b == 32'h0);
            count_q  <= 5'h0;
          end else if (ealuc == OP_MTHI) begin
            hi_q <= ea;
          end else if (ealuc == OP_MTLO) begin
            lo_q <= ea;
          end
        end
        S_BUSY: begin
          p_q     <= p_step;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            hi_q <= is_div_q ? div_hi : prod_fix[63:32];
            lo_q <= is_div_q ? div_lo : prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  // A stalled edge pushes a bubble into MEM
  always_ff @(posedge clk) begin
    if (!rst || stall) begin
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      malu_q   <= 32'h0;
      mb_q     <= 32'h0;
      mrn_q    <= 5'h0;
    end else begin
      mwreg_q  <= ewreg;
      mm2reg_q <= em2reg;
      mwmem_q  <= ewmem;
      malu_q   <= ealu;
      mb_q     <= eb;
      mrn_q    <= ern;
    end
  end

  assign mwreg  = mwreg_q;
  assign mm2reg = mm2reg_q;
  assign mwmem  = mwmem_q;
  assign malu   = malu_q;
  assign mb     = mb_q;
  assign mrn    = mrn_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ewreg, em2reg, ewmem, ejal, ealuimm;
  logic [4:0]  ealuc, eshamt, ern;
  logic [29:0] epc4;
  logic [31:0] ea, eb, eimm;
  logic        stall;
  logic [31:0] ealu;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int n;
  logic bub_bad;

  exe_stage dut (
    .clk(clk), .rst(rst), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ejal(ejal), .ealuimm(ealuimm), .ealuc(ealuc), .eshamt(eshamt),
    .epc4(epc4), .ea(ea), .eb(eb), .eimm(eimm), .ern(ern),
    .stall(stall), .ealu(ealu), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mul/div and wait through its stall window plus the DONE edge
  task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] bv,
                        output int cnt, output logic bub);
    ealuc = op; ea = a; eb = bv; ealuimm = 1'b0; ejal = 1'b0; ewreg = 1'b1; ern = 5'd3;
    cnt = 0;
    bub = 1'b0;
    #1;
    while (stall && cnt < 40) begin
      cnt++;
      tick();
      if (mwreg !== 1'b0) bub = 1'b1;
    end
    tick();
  endtask

  initial begin
    rst = 1'b0; ewreg = 0; em2reg = 0; ewmem = 0; ejal = 0; ealuimm = 0;
    ealuc = 5'd0; eshamt = 5'd0; ern = 5'd0; epc4 = 30'h0; ea = 0; eb = 0; eimm = 0;
    tick(); tick();
    chk("reset_mwreg", {63'h0, mwreg}, 64'h0);
    chk("reset_malu", {32'h0, malu}, 64'h0);
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_stall", {63'h0, stall}, 64'h0);
    rst = 1'b1;

    ewreg = 1'b1; ern = 5'd5; ea = 32'hFFFF_FFFF; eb = 32'h1;
    ealuc = 5'd0; #1;
    chk("add_ealu", {32'h0, ealu}, 64'h0);
    ealuc = 5'd0; eb = 32'h1; ea = 32'hFFFF_FFFF;
    tick();
    chk("add_malu", {32'h0, malu}, 64'h0);
    chk("add_mwreg", {63'h0, mwreg}, 64'h1);
    chk("add_mb", {32'h0, mb}, 64'h1);
    ealuc = 5'd6; tick();
    chk("slt_malu", {32'h0, malu}, 64'h1);
    ealuc = 5'd7; tick();
    chk("sltu_malu", {32'h0, malu}, 64'h0);
    ealuc = 5'd1; ea = 32'd10; ealuimm = 1'b1; eimm = 32'd3; tick();
    chk("subi_malu", {32'h0, malu}, 64'd7);
    ealuc = 5'd11; eimm = 32'h0000_ABCD; tick();
    chk("lui_malu", {32'h0, malu}, 64'hABCD_0000);
    ealuimm = 1'b0;

    ealuc = 5'd10; eb = 32'h8000_0000; eshamt = 5'd4; tick();
    chk("sra_malu", {32'h0, malu}, 64'hF800_0000);
    ealuc = 5'd13; ea = 32'd4; tick();
    chk("srlv_malu", {32'h0, malu}, 64'h0800_0000);

    ejal = 1'b1; epc4 = 30'h0010_0001; ern = 5'd31; #1;
    chk("jal_ealu", {32'h0, ealu}, 64'h0040_0008);
    tick();
    chk("jal_malu", {32'h0, malu}, 64'h0040_0008);
    chk("jal_mrn", {59'h0, mrn}, 64'd31);
    ejal = 1'b0;

    ealuc = 5'd22; ea = 32'h1234_5678; tick();
    chk("mthi", {32'h0, hi}, 64'h1234_5678);

    run_md(5'd16, 32'hFFFF_FFFD, 32'd5, n, bub_bad);
    chk("mult_stall_cycles", 64'(n), 64'd33);
    chk("mult_bubbles", {63'h0, bub_bad}, 64'h0);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult_advance_mwreg", {63'h0, mwreg}, 64'h1);
    chk("mult_advance_mrn", {59'h0, mrn}, 64'd3);

    run_md(5'd19, 32'd100, 32'd7, n, bub_bad);
    chk("divu_stall_cycles", 64'(n), 64'd33);
    ealuc = 5'd21; #1;
    chk("divu_mflo", {32'h0, ealu}, 64'd14);
    ealuc = 5'd20; #1;
    chk("divu_mfhi", {32'h0, ealu}, 64'd2);
    tick();
    chk("mfhi_malu", {32'h0, malu}, 64'd2);

    run_md(5'd18, 32'hFFFF_FFF9, 32'd2, n, bub_bad);
    ealuc = 5'd21; #1;
    chk("div_mflo", {32'h0, ealu}, 64'hFFFF_FFFD);
    ealuc = 5'd20; #1;
    chk("div_mfhi", {32'h0, ealu}, 64'hFFFF_FFFF);

    run_md(5'd19, 32'd9, 32'd0, n, bub_bad);
    chk("div0_stall_cycles", 64'(n), 64'd33);
    ealuc = 5'd21; #1;
    chk("div0_mflo", {32'h0, ealu}, 64'hFFFF_FFFF);
    ealuc = 5'd20; #1;
    chk("div0_mfhi", {32'h0, ealu}, 64'd9);

    ealuc = 5'd17; ea = 32'd123; eb = 32'd456; ewreg = 1'b1; #1;
    chk("multu_start_stall", {63'h0, stall}, 64'h1);
    tick();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0; ealuc = 5'd0; ewreg = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk("rst_mid_stall", {63'h0, stall}, 64'h0);
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    chk("rst_mid_mctl", {61'h0, mwreg, mm2reg, mwmem}, 64'h0);
    chk("rst_mid_malu_mb", {malu, mb}, 64'h0);
    chk("rst_mid_mrn", {59'h0, mrn}, 64'h0);

    run_md(5'd17, 32'd6, 32'd7, n, bub_bad);
    chk("multu_after_rst_cycles", 64'(n), 64'd33);
    chk("multu_after_rst_hilo", {hi, lo}, 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EXE pipeline register outputs and computes the ALU or link-address result. It runs MULT/MULTU/DIV/DIVU on an iterative 32-step unit that owns the HI/LO registers, stalling the front of the pipe while that unit is busy. The block also contains the EXE/MEM pipeline register that feeds the memory stage.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-low reset
- ewreg, em2reg, ewmem  in  1 each  control bits from ID/EXE
- ejal  in  1  link instruction
- ealuimm  in  1  operand B = eimm when 1, else eb
- ealuc  in  5  operation code (see Operation)
- eshamt  in  5  constant shift amount
- epc4  in  30  PC+4, bits [31:2]
- ea, eb, eimm  in  32 each  operands and extended immediate
- ern  in  5  destination register
- stall  out  1  hold PC, IF/ID and ID/EXE, combinational
- ealu  out  32  combinational EXE result for ID-stage forwarding
- mwreg, mm2reg, mwmem  out  1 each  registered control to MEM
- malu  out  32  registered result
- mb  out  32  registered store data (eb)
- mrn  out  5  registered destination
- hi, lo  out  32 each  HI/LO contents, for debug and bench

## Operation
- Operand B (b) is eimm when ealuimm=1, else eb.
- ealuc encoding, with results going to ealu:
  - 0 ADD: a+b. 1 SUB: a−b. Both wrap modulo 2^32 with no overflow trap.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed a<b gives 1, else 0. 7 SLTU: unsigned compare.
  - 8 SLL, 9 SRL, 10 SRA: eb shifted by eshamt.
  - 11 LUI: {b[15:0],16'h0}.
  - 12 SLLV, 13 SRLV, 14 SRAV: eb shifted by ea[4:0].
  - 16 MULT, 17 MULTU, 18 DIV, 19 DIVU: ealu = 0.
  - 20 MFHI: ealu = hi. 21 MFLO: ealu = lo.
  - 22 MTHI: hi ← ea. 23 MTLO: lo ← ea. Both write on a non-stalled edge; ealu = 0.
  - Any other code: ealu = 0.
- ejal=1 overrides ealuc: ealu = {epc4,2'b00}+4, i.e. the PC+8 link address.
- Mul/div FSM has three states: IDLE, BUSY, DONE.
  - IDLE with ealuc in 16..19: stall=1. At the edge, latch |a|/|b| (raw values for the unsigned ops), record the result signs, clear count, and go to BUSY.
  - BUSY: stall=1. Each edge performs one shift-add (mul) or one restoring-subtract (div) step and increments count. At the 32nd step, apply the sign fix-up, write hi/lo, and go to DONE.
  - DONE: stall=0. The instruction advances into EXE/MEM on this edge, and the FSM returns to IDLE.
- Mul results: {hi,lo} is the 64-bit product.
- Div results: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
- Divide by zero: lo = 32'hFFFFFFFF, hi = ea. Same latency, no trap.
- EXE/MEM register behaviour:
  - When stall=0, load ewreg, em2reg, ewmem, ealu, eb and ern.
  - When stall=1, insert a bubble: mwreg=0, mwmem=0, mm2reg=0, with data fields don't-care (driven 0).
- ea/eb are sampled only in IDLE. Upstream holds ID/EXE stable while stall=1.

## Timing
- ALU ops: one cycle. The result appears on malu one edge after the inputs are presented; ealu is valid in the same cycle.
- Mul/div instruction entering EXE at cycle T:
  - stall=1 for cycles T through T+32, i.e. 33 cycles.
  - hi/lo are updated at the end of T+32.
  - stall=0 at T+33, and the instruction reaches malu/mrn at the end of T+33.
- A back-to-back second mul/div present at T+34 restarts the FSM from IDLE.
- Reset (rst=0 at an edge): all registered outputs, hi, lo and count go to 0, and the FSM goes to IDLE. This holds mid-operation too: the operation is abandoned, hi/lo end at 0, and stall drops to 0 after the edge.

## Test plan
- ADD/SLT/SLTU with ea=32'hFFFFFFFF, eb=1, ealuimm=0:
  - ADD → malu=0.
  - SLT → 1.
  - SLTU → 0.
  - Each result appears on malu one cycle after its op is presented.
- Shifts:
  - SRA with eb=32'h80000000, eshamt=4 → 32'hF8000000.
  - SRLV with ea=4 on the same eb → 32'h08000000.
- JAL with epc4=30'h00100001 (PC+4 = 32'h00400004) and ern=31 → malu=32'h00400008, mrn=31.
- MULT with ea=−3, eb=5 → hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. Check stall high for exactly 33 cycles and mwreg=0 bubbles during the stall.
- Divides, each followed by MFLO/MFHI for readback:
  - DIVU 100/7 → lo=14, hi=2.
  - DIV −7/2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - DIVU x/0 with ea=9 → lo=32'hFFFFFFFF, hi=9.
- Drive rst=0 at BUSY step 10 of a MULTU → the next cycle shows stall=0, hi=lo=0 and all m* outputs 0. A new MULTU 6×7 then gives lo=42 and hi=0.
